// File: rtl/page_done_ctrl_if.sv
// Bus bundle between the page-completion controller and its surrounding datapath.
// The slave side is the controller; the master side drives status and pulses.
interface page_done_ctrl_if #(
    parameter int unsigned NUM_PARSER = 6,
    parameter int unsigned NUM_RAM    = 16,
    parameter int unsigned PCNT_W     = 16
);
    logic                  i_start;
    logic                  i_tf_empty;
    logic [NUM_PARSER-1:0] i_ps_empty;
    logic [NUM_RAM-1:0]    i_ram_empty;
    logic                  i_page_input_finish;
    logic                  i_cl_finish;
    logic                  o_page_finish;
    logic                  o_busy;
    logic                  o_timeout_err;
    logic [PCNT_W-1:0]     o_pages_done;

    modport slave (
        input  i_start, i_tf_empty, i_ps_empty, i_ram_empty,
               i_page_input_finish, i_cl_finish,
        output o_page_finish, o_busy, o_timeout_err, o_pages_done
    );

    modport master (
        output i_start, i_tf_empty, i_ps_empty, i_ram_empty,
               i_page_input_finish, i_cl_finish,
        input  o_page_finish, o_busy, o_timeout_err, o_pages_done
    );
endinterface

// File: rtl/page_done_ctrl.sv
// Page-completion controller: raises page_finish once all page input is consumed and
// the token FIFO, parsers and history banks have stayed empty for a quiet window.
module page_done_ctrl #(
    parameter int unsigned NUM_PARSER   = 6,
    parameter int unsigned NUM_RAM      = 16,
    parameter int unsigned QUIET_CYCLES = 16,
    parameter int unsigned TIMEOUT_W    = 20,
    parameter int unsigned PCNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    page_done_ctrl_if.slave   bus
);

    localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
    localparam logic [QW-1:0] QUIET_MAX  = QW'(QUIET_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_DRAIN  = 3'd2,
        S_DONE   = 3'd3,
        S_WRAP   = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_all_empty_q;
    logic [QW-1:0]         r_quiet_cnt;
    logic [TIMEOUT_W-1:0]  r_wd_cnt;
    logic                  r_in_done;
    logic                  r_next_pend;
    logic                  r_page_finish;
    logic                  r_timeout_err;
    logic [PCNT_W-1:0]     r_pages_done;

    state_t                w_state_nxt;
    logic                  w_all_empty;
    logic [QW-1:0]         w_quiet_nxt;
    logic [TIMEOUT_W-1:0]  w_wd_nxt;
    logic                  w_in_done_nxt;
    logic                  w_next_pend_nxt;
    logic                  w_page_finish_nxt;
    logic                  w_timeout_err_nxt;
    logic [PCNT_W-1:0]     w_pages_done_nxt;

    assign w_all_empty = (&bus.i_ps_empty) & (&bus.i_ram_empty) & bus.i_tf_empty;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_all_empty_q <= 1'b0;
            r_quiet_cnt   <= '0;
            r_wd_cnt      <= '0;
            r_in_done     <= 1'b0;
            r_next_pend   <= 1'b0;
            r_page_finish <= 1'b0;
            r_timeout_err <= 1'b0;
            r_pages_done  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_all_empty_q <= w_all_empty;
            r_quiet_cnt   <= w_quiet_nxt;
            r_wd_cnt      <= w_wd_nxt;
            r_in_done     <= w_in_done_nxt;
            r_next_pend   <= w_next_pend_nxt;
            r_page_finish <= w_page_finish_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_pages_done  <= w_pages_done_nxt;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        w_state_nxt       = r_state;
        w_quiet_nxt       = r_quiet_cnt;
        w_wd_nxt          = r_wd_cnt;
        w_in_done_nxt     = r_in_done;
        w_next_pend_nxt   = r_next_pend;
        w_page_finish_nxt = r_page_finish;
        w_timeout_err_nxt = r_timeout_err;
        w_pages_done_nxt  = r_pages_done;

        case (r_state)
            S_IDLE: begin
                w_in_done_nxt   = r_next_pend | bus.i_page_input_finish;
                w_next_pend_nxt = 1'b0;
                if (bus.i_start) begin
                    w_timeout_err_nxt = 1'b0;
                end
                if (bus.i_start || !bus.i_tf_empty) begin
                    w_state_nxt = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (bus.i_page_input_finish) begin
                    w_in_done_nxt = 1'b1;
                end
                if (r_in_done && bus.i_tf_empty) begin
                    w_state_nxt = S_DRAIN;
                    w_quiet_nxt = '0;
                    w_wd_nxt    = '0;
                end
            end

            S_DRAIN: begin
                if (bus.i_page_input_finish) begin
                    w_in_done_nxt = 1'b1;
                end
                w_wd_nxt = r_wd_cnt + TIMEOUT_W'(1);
                if (r_all_empty_q) begin
                    w_quiet_nxt = (r_quiet_cnt == QUIET_MAX) ? r_quiet_cnt
                                                             : r_quiet_cnt + QW'(1);
                end else begin
                    w_quiet_nxt = '0;
                end
                // A genuine quiet window wins over a watchdog expiring on the same cycle
                if (r_all_empty_q && (r_quiet_cnt == QUIET_LAST)) begin
                    w_state_nxt       = S_DONE;
                    w_page_finish_nxt = 1'b1;
                end else if (&r_wd_cnt) begin
                    w_state_nxt       = S_DONE;
                    w_page_finish_nxt = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                end
            end

            S_DONE: begin
                w_page_finish_nxt = 1'b1;
                if (bus.i_page_input_finish) begin
                    w_next_pend_nxt = 1'b1;
                end
                if (bus.i_cl_finish) begin
                    w_state_nxt       = S_WRAP;
                    w_page_finish_nxt = 1'b0;
                end else if (!r_all_empty_q && !r_timeout_err) begin
                    w_state_nxt       = S_DRAIN;
                    w_page_finish_nxt = 1'b0;
                    w_quiet_nxt       = '0;
                end
            end

            S_WRAP: begin
                w_pages_done_nxt = r_pages_done + PCNT_W'(1);
                w_in_done_nxt    = 1'b0;
                if (r_next_pend || bus.i_page_input_finish) begin
                    w_state_nxt     = S_ACTIVE;
                    w_in_done_nxt   = 1'b1;
                    w_next_pend_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt       = S_IDLE;
                w_page_finish_nxt = 1'b0;
            end
        endcase
    end

    assign bus.o_page_finish = r_page_finish;
    assign bus.o_timeout_err = r_timeout_err;
    assign bus.o_pages_done  = r_pages_done;
    assign bus.o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_page_done_ctrl.sv
// Directed bench for page_done_ctrl: one instance with the default watchdog and one
// with a 4-bit watchdog for the timeout scenario.
module tb_page_done_ctrl;

    localparam int unsigned NP = 6;
    localparam int unsigned NR = 16;
    localparam int unsigned PW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    page_done_ctrl_if #(.NUM_PARSER(NP), .NUM_RAM(NR), .PCNT_W(PW)) bus_a ();
    page_done_ctrl_if #(.NUM_PARSER(NP), .NUM_RAM(NR), .PCNT_W(PW)) bus_b ();

    page_done_ctrl #(
        .NUM_PARSER(NP), .NUM_RAM(NR), .QUIET_CYCLES(16), .TIMEOUT_W(20), .PCNT_W(PW)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    page_done_ctrl #(
        .NUM_PARSER(NP), .NUM_RAM(NR), .QUIET_CYCLES(16), .TIMEOUT_W(4), .PCNT_W(PW)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_a.i_start = 1'b0;  bus_a.i_tf_empty = 1'b1;
        bus_a.i_ps_empty = '0; bus_a.i_ram_empty = '1;
        bus_a.i_page_input_finish = 1'b0; bus_a.i_cl_finish = 1'b0;
        bus_b.i_start = 1'b0;  bus_b.i_tf_empty = 1'b1;
        bus_b.i_ps_empty = 6'h3E; bus_b.i_ram_empty = '1;
        bus_b.i_page_input_finish = 1'b0; bus_b.i_cl_finish = 1'b0;

        // Reset values
        #3;
        chk("rst_pf",    bus_a.o_page_finish, 0);
        chk("rst_busy",  bus_a.o_busy,        0);
        chk("rst_tout",  bus_a.o_timeout_err, 0);
        chk("rst_pages", bus_a.o_pages_done,  0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        // 1 Nominal page
        bus_a.i_start = 1'b1;
        cyc(1);
        bus_a.i_start = 1'b0;
        chk("t1_busy", bus_a.o_busy, 1);
        cyc(8);
        bus_a.i_page_input_finish = 1'b1;
        cyc(1);
        bus_a.i_page_input_finish = 1'b0;
        cyc(1);
        bus_a.i_ps_empty = '1;
        cyc(16);
        chk("t1_pf_early", bus_a.o_page_finish, 0);
        cyc(1);
        chk("t1_pf", bus_a.o_page_finish, 1);
        bus_a.i_cl_finish = 1'b1;
        cyc(1);
        bus_a.i_cl_finish = 1'b0;
        chk("t1_pf_drop", bus_a.o_page_finish, 0);
        cyc(1);
        chk("t1_pages", bus_a.o_pages_done, 1);
        chk("t1_idle",  bus_a.o_busy,       0);

        // 2 Glitch after 10 quiet cycles restarts the window
        bus_a.i_ps_empty = '0;
        bus_a.i_start = 1'b1;
        bus_a.i_page_input_finish = 1'b1;
        cyc(1);
        bus_a.i_start = 1'b0;
        bus_a.i_page_input_finish = 1'b0;
        cyc(1);
        bus_a.i_ps_empty = '1;
        cyc(10);
        bus_a.i_ps_empty = 6'h37;
        cyc(1);
        bus_a.i_ps_empty = '1;
        cyc(16);
        chk("t2_pf_early", bus_a.o_page_finish, 0);
        cyc(1);
        chk("t2_pf", bus_a.o_page_finish, 1);

        // 3 Revoke from DONE, then refinish
        bus_a.i_ram_empty = 16'hFF7F;
        cyc(1);
        bus_a.i_ram_empty = '1;
        chk("t3_hold", bus_a.o_page_finish, 1);
        cyc(1);
        chk("t3_revoke", bus_a.o_page_finish, 0);
        chk("t3_busy",   bus_a.o_busy,        1);
        cyc(15);
        chk("t3_pf_early", bus_a.o_page_finish, 0);
        cyc(1);
        chk("t3_pf", bus_a.o_page_finish, 1);

        // 4 Next page's input finish arrives with cl_finish
        bus_a.i_cl_finish = 1'b1;
        bus_a.i_page_input_finish = 1'b1;
        cyc(1);
        bus_a.i_cl_finish = 1'b0;
        bus_a.i_page_input_finish = 1'b0;
        chk("t4_wrap_pf", bus_a.o_page_finish, 0);
        cyc(1);
        chk("t4_pages", bus_a.o_pages_done, 2);
        chk("t4_busy",  bus_a.o_busy,       1);
        cyc(16);
        chk("t4_pf_early", bus_a.o_page_finish, 0);
        cyc(1);
        chk("t4_pf", bus_a.o_page_finish, 1);
        bus_a.i_cl_finish = 1'b1;
        cyc(1);
        bus_a.i_cl_finish = 1'b0;
        cyc(1);
        chk("t4_pages2", bus_a.o_pages_done, 3);
        chk("t4_idle",   bus_a.o_busy,       0);

        // 5 Watchdog on the 4-bit instance
        bus_b.i_start = 1'b1;
        bus_b.i_page_input_finish = 1'b1;
        cyc(1);
        bus_b.i_start = 1'b0;
        bus_b.i_page_input_finish = 1'b0;
        cyc(1);
        cyc(15);
        chk("t5_pf_early",   bus_b.o_page_finish, 0);
        chk("t5_tout_early", bus_b.o_timeout_err, 0);
        cyc(1);
        chk("t5_pf",   bus_b.o_page_finish, 1);
        chk("t5_tout", bus_b.o_timeout_err, 1);
        cyc(2);
        chk("t5_no_revoke", bus_b.o_page_finish, 1);
        bus_b.i_cl_finish = 1'b1;
        cyc(1);
        bus_b.i_cl_finish = 1'b0;
        chk("t5_pf_drop", bus_b.o_page_finish, 0);
        cyc(1);
        chk("t5_pages",       bus_b.o_pages_done,  1);
        chk("t5_tout_sticky", bus_b.o_timeout_err, 1);
        chk("t5_idle",        bus_b.o_busy,        0);
        bus_b.i_start = 1'b1;
        cyc(1);
        bus_b.i_start = 1'b0;
        chk("t5_tout_clr", bus_b.o_timeout_err, 0);
        chk("t5_busy",     bus_b.o_busy,        1);

        // 6 Async reset in the middle of a quiet count
        bus_a.i_start = 1'b1;
        bus_a.i_page_input_finish = 1'b1;
        cyc(1);
        bus_a.i_start = 1'b0;
        bus_a.i_page_input_finish = 1'b0;
        cyc(6);
        chk("t6_pre_busy", bus_a.o_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy",   bus_a.o_busy,        0);
        chk("t6_pages",  bus_a.o_pages_done,  0);
        chk("t6_pf",     bus_a.o_page_finish, 0);
        chk("t6_tout",   bus_a.o_timeout_err, 0);
        chk("t6_b_busy", bus_b.o_busy,        0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        bus_a.i_cl_finish = 1'b1;
        cyc(1);
        bus_a.i_cl_finish = 1'b0;
        cyc(1);
        chk("t6_stray_busy",  bus_a.o_busy,        0);
        chk("t6_stray_pages", bus_a.o_pages_done,  0);
        chk("t6_stray_pf",    bus_a.o_page_finish, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
